// File: rtl/sprite_blitter.sv
// Raster-scans a sprite ROM and emits clipped, colour-keyed pixels to the VGA adapter.
// Two-stage pipeline: ROM read latency aligned with delayed col/row, then registered pixel outputs.
module sprite_blitter #(
    parameter int         SPR_W       = 32,
    parameter int         SPR_H       = 32,
    parameter int         SCR_W       = 160,
    parameter int         SCR_H       = 120,
    parameter int         ADDR_W      = 10,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        sprite_sel,
    input  logic [7:0]        x0,
    input  logic [6:0]        y0,
    output logic              busy,
    output logic              done,
    output logic [1:0]        rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              plot
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_SCAN  | issuing one ROM address per cycle
    // S_FLUSH | two cycles draining the ROM/output pipeline
    // S_DONE  | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    x0_q, x0_d;
    logic [6:0]    y0_q, y0_d;
    logic          flush_cnt_q, flush_cnt_d;
    logic          s1_valid_q, s1_valid_d;
    logic [CW-1:0] s1_col_q, s1_col_d;
    logic [RW-1:0] s1_row_q, s1_row_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d;
    logic [8:0]    sx;
    logic [7:0]    sy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            sel_q       <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            flush_cnt_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sel_q       <= sel_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            flush_cnt_q <= flush_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sel_d       = sel_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = sprite_sel;
                    x0_d    = x0;
                    y0_d    = y0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (col_q == CW'(SPR_W - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(SPR_H - 1)) begin
                        row_d       = '0;
                        flush_cnt_d = 1'b1;
                        state_d     = S_FLUSH;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 1'b0) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stage 1 delays the scan position so it lines up with the ROM's registered output.
    always_comb begin
        s1_valid_d = (state_q == S_SCAN);
        s1_col_d   = col_q;
        s1_row_d   = row_q;
    end

    always_comb begin
        sx       = {1'b0, x0_q} + 9'(s1_col_q);
        sy       = {1'b0, y0_q} + 8'(s1_row_q);
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (s1_valid_q) begin
            x_d      = sx[7:0];
            y_d      = sy[6:0];
            colour_d = rom_data;
            plot_d   = (rom_data != TRANSPARENT) && (sx < 9'(SCR_W)) && (sy < 8'(SCR_H));
        end
    end

    assign rom_addr = ADDR_W'(row_q) * ADDR_W'(SPR_W) + ADDR_W'(col_q);
    assign rom_sel  = sel_q;
    assign busy     = (state_q == S_SCAN) || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a 4x4 sprite and a synchronous ROM model.
module tb_sprite_blitter;

    localparam int NC = 22;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sprite_sel = '0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic       busy, done, plot;
    logic [1:0] rom_sel;
    logic [3:0] rom_addr;
    logic [2:0] rom_data = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    logic [2:0] rom_mem [0:15];

    int checks = 0;
    int errors = 0;

    logic       rec_busy   [0:NC];
    logic       rec_done   [0:NC];
    logic       rec_plot   [0:NC];
    logic [7:0] rec_x      [0:NC];
    logic [6:0] rec_y      [0:NC];
    logic [2:0] rec_colour [0:NC];
    logic [3:0] rec_addr   [0:NC];
    logic [1:0] rec_sel    [0:NC];

    sprite_blitter #(
        .SPR_W(4), .SPR_H(4), .SCR_W(160), .SCR_H(120), .ADDR_W(4), .TRANSPARENT(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sprite_sel(sprite_sel),
        .x0(x0), .y0(y0), .busy(busy), .done(done), .rom_sel(rom_sel),
        .rom_addr(rom_addr), .rom_data(rom_data), .x(x), .y(y),
        .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic fill_rom(input logic [2:0] v);
        for (int i = 0; i < 16; i++) rom_mem[i] = v;
    endtask

    // Called in cycle 0 (just after an edge); records cycles 1..NC.
    task automatic draw(input logic [1:0] sel, input logic [7:0] ax, input logic [6:0] ay,
                        input bit hold, input bit pulses);
        sprite_sel = sel;
        x0 = ax;
        y0 = ay;
        start = 1'b1;
        for (int c = 1; c <= NC; c++) begin
            tick();
            rec_busy[c]   = busy;
            rec_done[c]   = done;
            rec_plot[c]   = plot;
            rec_x[c]      = x;
            rec_y[c]      = y;
            rec_colour[c] = colour;
            rec_addr[c]   = rom_addr;
            rec_sel[c]    = rom_sel;
            start = hold;
            if (pulses && (c == 5 || c == 18)) begin
                start = 1'b1;
                sprite_sel = 2'd3;
                x0 = 8'd0;
                y0 = 7'd0;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_draw(input string tag, input int ax, input int ay,
                              input logic [1:0] sel, input int nplots);
        int cnt;
        int k, sx, sy;
        bit pix, eplot;
        cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            pix = (c >= 3) && (c <= 18);
            k = c - 3;
            sx = ax + (k % 4);
            sy = ay + (k / 4);
            eplot = pix && (rom_mem[k & 15] != 3'b000) && (sx < 160) && (sy < 120);
            chk({tag, "_busy"}, c, 32'(rec_busy[c]), 32'(c <= 18));
            chk({tag, "_done"}, c, 32'(rec_done[c]), 32'(c == 19));
            chk({tag, "_plot"}, c, 32'(rec_plot[c]), 32'(eplot));
            if (pix) begin
                chk({tag, "_x"}, c, 32'(rec_x[c]), 32'(sx & 255));
                chk({tag, "_y"}, c, 32'(rec_y[c]), 32'(sy & 127));
                chk({tag, "_colour"}, c, 32'(rec_colour[c]), 32'(rom_mem[k]));
            end
            if (c <= 16) chk({tag, "_addr"}, c, 32'(rec_addr[c]), 32'(c - 1));
            if (rec_plot[c] === 1'b1) cnt++;
        end
        chk({tag, "_count"}, 0, 32'(cnt), 32'(nplots));
        chk({tag, "_rom_sel"}, 20, 32'(rec_sel[20]), 32'(sel));
    endtask

    initial begin
        fill_rom(3'b101);
        sprite_sel = 2'($urandom);
        x0 = 8'($urandom);
        y0 = 7'($urandom);
        start = 1'b1;
        #3;
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_plot", 0, 32'(plot), 0);
        chk("rst_x", 0, 32'(x), 0);
        chk("rst_y", 0, 32'(y), 0);
        chk("rst_addr", 0, 32'(rom_addr), 0);
        repeat (2) tick();
        reset = 1'b0;
        start = 1'b0;
        tick();

        fill_rom(3'b101);
        draw(2'd1, 8'd10, 7'd20, 1'b0, 1'b0);
        check_draw("basic", 10, 20, 2'd1, 16);

        fill_rom(3'b010);
        rom_mem[0] = 3'b000;
        rom_mem[5] = 3'b000;
        draw(2'd2, 8'd10, 7'd20, 1'b0, 1'b0);
        check_draw("transp", 10, 20, 2'd2, 14);
        chk("transp_plot3", 3, 32'(rec_plot[3]), 0);
        chk("transp_plot8", 8, 32'(rec_plot[8]), 0);

        fill_rom(3'b110);
        draw(2'd3, 8'd158, 7'd118, 1'b0, 1'b0);
        check_draw("clip", 158, 118, 2'd3, 4);
        chk("clip_first_x", 3, 32'(rec_x[3]), 158);
        chk("clip_last_y", 8, 32'(rec_y[8]), 119);

        fill_rom(3'b101);
        draw(2'd2, 8'd30, 7'd40, 1'b0, 1'b1);
        check_draw("ignore", 30, 40, 2'd2, 16);
        chk("ignore_idle", 20, 32'(rec_busy[20]), 0);

        fill_rom(3'b011);
        draw(2'd0, 8'd5, 7'd6, 1'b1, 1'b0);
        check_draw("hold", 5, 6, 2'd0, 16);
        chk("hold_busy20", 20, 32'(rec_busy[20]), 0);
        chk("hold_busy21", 21, 32'(rec_busy[21]), 1);
        chk("hold_addr21", 21, 32'(rec_addr[21]), 0);
        chk("hold_addr22", 22, 32'(rec_addr[22]), 1);
        start = 1'b0;
        repeat (25) tick();
        chk("hold_drained", 0, 32'(busy), 0);

        fill_rom(3'b101);
        sprite_sel = 2'd1;
        x0 = 8'd10;
        y0 = 7'd20;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        chk("mid_pre_x", 10, 32'(x), 13);
        chk("mid_pre_y", 10, 32'(y), 21);
        chk("mid_pre_busy", 10, 32'(busy), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_plot", 10, 32'(plot), 0);
        chk("mid_busy", 10, 32'(busy), 0);
        chk("mid_x", 10, 32'(x), 0);
        chk("mid_addr", 10, 32'(rom_addr), 0);
        chk("mid_done", 10, 32'(done), 0);
        for (int c = 11; c <= 13; c++) begin
            tick();
            chk("mid_no_done", c, 32'(done), 0);
        end
        reset = 1'b0;
        tick();
        chk("post_rst_done", 0, 32'(done), 0);
        draw(2'd1, 8'd10, 7'd20, 1'b0, 1'b0);
        check_draw("post_rst", 10, 20, 2'd1, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Draws one rectangular sprite from a synchronous sprite ROM into the 160x120 VGA frame buffer at a requested origin.
- Sits between the game control FSM (upstream: start pulse, sprite select, origin) and vga_adapter (downstream: x, y, colour, plot).
- Replaces full-screen image copying with positioned, clipped, transparency-keyed sprite draws.

Parameters:
- SPR_W, 32, sprite width in pixels.
- SPR_H, 32, sprite height in pixels.
- SCR_W, 160, screen width; pixels with x >= SCR_W are clipped.
- SCR_H, 120, screen height; pixels with y >= SCR_H are clipped.
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
- TRANSPARENT, 3'b000, colour key that is never plotted.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  draw request; sampled only while busy=0.
- sprite_sel  in  2  sprite to draw; latched on accepted start.
- x0  in  8  sprite top-left x; latched on accepted start.
- y0  in  7  sprite top-left y; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the last pixel output.
- done  out  1  one-cycle pulse after the last pixel output.
- rom_sel  out  2  latched sprite_sel, driven to the ROM bank mux.
- rom_addr  out  ADDR_W  row*SPR_W+col.
- rom_data  in  3  ROM colour; valid 1 cycle after rom_addr.
- x  out  8  frame-buffer x to vga_adapter.
- y  out  7  frame-buffer y to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  write enable to vga_adapter.

Behaviour:
- Reset (async, any state):
  - State=IDLE.
  - busy, done, plot = 0.
  - x, y, colour, rom_addr, rom_sel, col, row = 0.
- FSM states: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - If start=1, latch sprite_sel, x0 and y0, clear col and row, and go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - Issue one rom_addr per cycle in raster order: col counts 0..SPR_W-1, then wraps to 0 and row increments.
  - After issuing address SPR_W*SPR_H-1, go to FLUSH.
- FLUSH: wait 2 cycles for the pipeline to drain, then go to DONE.
- DONE: assert done=1 and busy=0 for one cycle, then go to IDLE.
- start is ignored in every state except IDLE. No queuing.
- Pipeline alignment:
  - Stage 1: col and row are delayed one cycle so they align with rom_data.
  - Stage 2: x, y, colour and plot are registered from stage 1.
- Timing, with start accepted at cycle 0 and N = SPR_W*SPR_H:
  - Pixel k's address appears in cycle 1+k.
  - Pixel k's outputs are visible in cycle 3+k.
  - busy=1 in cycles 1..N+2.
  - done=1 in cycle N+3. A new start can be accepted in cycle N+3.
- Coordinate arithmetic:
  - sx = x0 + col, computed 9 bits wide.
  - sy = y0 + row, computed 8 bits wide.
  - x and y outputs take the low 8 and 7 bits of sx and sy.
- plot=1 only when all of the following hold:
  - the pixel is a valid pipeline pixel;
  - rom_data != TRANSPARENT;
  - sx < SCR_W and sy < SCR_H.
- Transparent or clipped pixels still consume their cycle; x and y still update and colour = rom_data.
- plot=0 in every cycle that does not carry a pipeline pixel.
- Reset mid-draw: outputs drop to reset values in the same cycle (async). No partial done pulse.
- start held high continuously: the next draw starts in the DONE cycle's successor only if start is still high in IDLE.
  - Back-to-back spacing is exactly N+4 cycles.

Test Plan:
- Reset behaviour: assert reset mid-cycle with random inputs -> busy, done, plot, x, y, rom_addr all 0 immediately; state returns to IDLE.
- Basic draw: SPR_W=SPR_H=4, ROM all 3'b101, start with x0=10, y0=20 ->
  - 16 plots in cycles 3..18;
  - first pixel x=10, y=20; last pixel x=13, y=23; colour 3'b101;
  - done=1 in cycle 19 only; busy=1 in cycles 1..18.
- Transparency: ROM addresses 0 and 5 hold 3'b000, others 3'b010 -> plot=0 in cycles 3 and 8, plot=1 in the other 14 cycles; x/y sequence unchanged.
- Clipping: x0=158, y0=118, 4x4 sprite, opaque ROM -> exactly 4 plots, at (158,118), (159,118), (158,119), (159,119); done still arrives in cycle 19.
- Busy/start interaction:
  - Pulse start again at cycles 5 and 18 -> ignored; rom_sel and origin are unchanged.
  - Hold start high -> second draw's first rom_addr=0 appears in cycle 21.
- Reset mid-operation: assert reset at cycle 10 of a draw -> plot=0 and busy=0 at once, no done pulse; a fresh start after release draws from address 0.
